// File: rtl/acia_pkg.sv
// Shared definitions for the ACIA bus sequencer: register addresses,
// status bit positions and the sequencer state encoding.
package acia_pkg;

    localparam logic [1:0] RS_DATA   = 2'b00;
    localparam logic [1:0] RS_STATUS = 2'b01;
    localparam logic [1:0] RS_CMD    = 2'b10;
    localparam logic [1:0] RS_CTRL   = 2'b11;

    localparam int ST_OVR  = 2;
    localparam int ST_RDRF = 3;
    localparam int ST_TDRE = 4;

    typedef enum logic [3:0] {
        S_INIT_RST,
        S_GAP1,
        S_INIT_CTRL,
        S_GAP2,
        S_INIT_CMD,
        S_IDLE,
        S_POLL,
        S_DECIDE,
        S_TX_WR,
        S_RX_RD,
        S_WAIT
    } state_t;

endpackage

// File: rtl/acia_rr_arb2.sv
// Two-way round-robin arbiter. The requester granted last loses a tie;
// out of reset B counts as last granted, so A wins the first tie.
module acia_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic [1:0] o_gnt
);

    logic r_last_b;

    // Grant selection from live requests and the last-granted pointer
    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = r_last_b ? 2'b01 : 2'b10;
        end
    end

    // Pointer moves only when a grant is actually consumed
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_b <= 1'b1;
        end else if (i_take && (|o_gnt)) begin
            r_last_b <= o_gnt[1];
        end
    end

endmodule

// File: rtl/acia_bus_seq.sv
// ACIA (6551-style) CPU-bus sequencer: init writes, status polling,
// round-robin TX from two requesters, optional RX path.
// Optional receive path enabled by defining ACIA_SEQ_RX_EN.
//
// state       | meaning
// INIT_RST    | programmed reset write (status reg), held while in reset
// GAP1/GAP2   | bus separator cycles during init
// INIT_CTRL   | write CTRL_INIT to control reg
// INIT_CMD    | write CMD_INIT to command reg
// IDLE        | bus quiet, waiting for work
// POLL        | read status reg
// DECIDE      | act on sampled status and live TX valids
// TX_WR       | write granted byte to data reg, pulse its READY
// RX_RD       | read data reg into RX holding register
// WAIT        | back-off of POLL_GAP cycles after an empty poll
module acia_bus_seq
    import acia_pkg::*;
#(
    parameter logic [7:0] CTRL_INIT = 8'h1E,
    parameter logic [7:0] CMD_INIT  = 8'h0B,
    parameter int         POLL_GAP  = 4
) (
    input  logic       i_phi2,
    input  logic       i_reset,
    input  logic       i_txa_valid,
    input  logic [7:0] i_txa_data,
    output logic       o_txa_ready,
    input  logic       i_txb_valid,
    input  logic [7:0] i_txb_data,
    output logic       o_txb_ready,
`ifdef ACIA_SEQ_RX_EN
    output logic       o_rx_valid,
    output logic [7:0] o_rx_data,
    input  logic       i_rx_ready,
`endif
    output logic       o_rx_ovr,
    output logic       o_init_done,
    output logic       o_cs,
    output logic       o_rwn,
    output logic [1:0] o_rs,
    output logic [7:0] o_bus_wdata,
    input  logic [7:0] i_bus_rdata
);

    localparam int WCW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    state_t         r_state;
    state_t         w_state_next;
    logic           r_armed;
    logic           r_tdre;
    logic           r_gnt_b;
    logic [WCW-1:0] r_wait_cnt;
    logic           r_rx_ovr;
    logic           r_init_done;
    logic           w_cs;
    logic           w_rwn;
    logic [1:0]     w_rs;
    logic [7:0]     w_wdata;
    logic           w_tx_any;
    logic           w_rx_free;
    logic           w_rdrf;
    logic           w_rx_take;
    logic           w_tx_take;
    logic [1:0]     w_gnt;

`ifdef ACIA_SEQ_RX_EN
    logic           r_rdrf;
    logic           r_rx_valid;
    logic [7:0]     r_rx_data;
    assign w_rx_free = ~r_rx_valid;
    assign w_rdrf    = r_rdrf;
`else
    logic           w_unused_rdata;
    assign w_rx_free      = 1'b0;
    assign w_rdrf         = 1'b0;
    assign w_unused_rdata = ^{i_bus_rdata[7:5], i_bus_rdata[3], i_bus_rdata[1:0]};
`endif

    assign w_tx_any  = i_txa_valid | i_txb_valid;
    assign w_rx_take = w_rdrf & w_rx_free;
    assign w_tx_take = (r_state == S_DECIDE) & ~w_rx_take & r_tdre & w_tx_any;

    acia_rr_arb2 u_arb (
        .i_clk  (i_phi2),
        .i_rst  (i_reset),
        .i_req  ({i_txb_valid, i_txa_valid}),
        .i_take (w_tx_take),
        .o_gnt  (w_gnt)
    );

    // Next-state selection
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_INIT_RST:  if (r_armed) w_state_next = S_GAP1;
            S_GAP1:      w_state_next = S_INIT_CTRL;
            S_INIT_CTRL: w_state_next = S_GAP2;
            S_GAP2:      w_state_next = S_INIT_CMD;
            S_INIT_CMD:  w_state_next = S_IDLE;
            S_IDLE:      if (w_tx_any || w_rx_free) w_state_next = S_POLL;
            S_POLL:      w_state_next = S_DECIDE;
            S_DECIDE: begin
                if (w_rx_take)      w_state_next = S_RX_RD;
                else if (w_tx_take) w_state_next = S_TX_WR;
                else                w_state_next = S_WAIT;
            end
            S_TX_WR:     w_state_next = S_IDLE;
            S_RX_RD:     w_state_next = S_IDLE;
            S_WAIT:      if (r_wait_cnt == '0) w_state_next = S_IDLE;
            default:     w_state_next = S_INIT_RST;
        endcase
    end

    // Bus drive decoded from the current state; INIT_RST only drives once armed
    always_comb begin
        w_cs    = 1'b1;
        w_rwn   = 1'b1;
        w_rs    = RS_DATA;
        w_wdata = 8'h00;
        case (r_state)
            S_INIT_RST: if (r_armed) begin
                w_cs  = 1'b0;
                w_rwn = 1'b0;
                w_rs  = RS_STATUS;
            end
            S_INIT_CTRL: begin
                w_cs    = 1'b0;
                w_rwn   = 1'b0;
                w_rs    = RS_CTRL;
                w_wdata = CTRL_INIT;
            end
            S_INIT_CMD: begin
                w_cs    = 1'b0;
                w_rwn   = 1'b0;
                w_rs    = RS_CMD;
                w_wdata = CMD_INIT;
            end
            S_POLL: begin
                w_cs = 1'b0;
                w_rs = RS_STATUS;
            end
            S_TX_WR: begin
                w_cs    = 1'b0;
                w_rwn   = 1'b0;
                w_wdata = r_gnt_b ? i_txb_data : i_txa_data;
            end
            S_RX_RD: w_cs = 1'b0;
            default: ;
        endcase
    end

    // Reset arriving mid-access drops CS and suppresses the READY pulse at once
    assign o_cs        = w_cs | i_reset;
    assign o_rwn       = w_rwn;
    assign o_rs        = w_rs;
    assign o_bus_wdata = w_wdata;
    assign o_txa_ready = (r_state == S_TX_WR) & ~r_gnt_b & ~i_reset;
    assign o_txb_ready = (r_state == S_TX_WR) &  r_gnt_b & ~i_reset;
    assign o_rx_ovr    = r_rx_ovr;
    assign o_init_done = r_init_done;

    // State, status sampling, back-off timer and sticky flags
    always_ff @(posedge i_phi2) begin
        if (i_reset) begin
            r_state     <= S_INIT_RST;
            r_armed     <= 1'b0;
            r_tdre      <= 1'b0;
            r_gnt_b     <= 1'b0;
            r_wait_cnt  <= '0;
            r_rx_ovr    <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_armed <= 1'b1;
            if (r_state == S_POLL) begin
                r_tdre <= i_bus_rdata[ST_TDRE];
                if (i_bus_rdata[ST_OVR]) r_rx_ovr <= 1'b1;
            end
            if (r_state == S_DECIDE) begin
                r_gnt_b    <= w_gnt[1];
                r_wait_cnt <= WCW'(POLL_GAP - 1);
            end else if ((r_state == S_WAIT) && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end
            if (r_state == S_INIT_CMD) r_init_done <= 1'b1;
        end
    end

`ifdef ACIA_SEQ_RX_EN
    // Receive holding register: loaded from the data read, freed by handshake
    always_ff @(posedge i_phi2) begin
        if (i_reset) begin
            r_rdrf     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'h00;
        end else begin
            if (r_state == S_POLL) r_rdrf <= i_bus_rdata[ST_RDRF];
            if (r_state == S_RX_RD) begin
                r_rx_data  <= i_bus_rdata;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && i_rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign o_rx_valid = r_rx_valid;
    assign o_rx_data  = r_rx_data;
`endif

endmodule

// File: tb/tb_acia_bus_seq.sv
// Directed bench for acia_bus_seq with a behavioural ACIA read model.
module tb_acia_bus_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       txa_valid, txb_valid;
    logic [7:0] txa_data, txb_data;
    logic       txa_ready, txb_ready;
    logic       rx_ovr, init_done, cs, rwn;
    logic [1:0] rs;
    logic [7:0] wdata, rdata;
    logic [7:0] acia_status, acia_rxd;
`ifdef ACIA_SEQ_RX_EN
    logic       rx_valid, rx_ready;
    logic [7:0] rx_data;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rdata = (rs == 2'b01) ? acia_status : acia_rxd;

    acia_bus_seq dut (
        .i_phi2      (clk),
        .i_reset     (rst),
        .i_txa_valid (txa_valid),
        .i_txa_data  (txa_data),
        .o_txa_ready (txa_ready),
        .i_txb_valid (txb_valid),
        .i_txb_data  (txb_data),
        .o_txb_ready (txb_ready),
`ifdef ACIA_SEQ_RX_EN
        .o_rx_valid  (rx_valid),
        .o_rx_data   (rx_data),
        .i_rx_ready  (rx_ready),
`endif
        .o_rx_ovr    (rx_ovr),
        .o_init_done (init_done),
        .o_cs        (cs),
        .o_rwn       (rwn),
        .o_rs        (rs),
        .o_bus_wdata (wdata),
        .i_bus_rdata (rdata)
    );

    task automatic reset_init();
        txa_valid = 0; txb_valid = 0;
`ifdef ACIA_SEQ_RX_EN
        rx_ready = 0;
`endif
        @(negedge clk); rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (7) @(negedge clk);
    endtask

    task automatic test_reset();
        logic       e_cs;
        logic [1:0] e_rs;
        logic [7:0] e_d;
        txa_valid = 1; txa_data = 8'h33; txb_valid = 0; acia_status = 8'h00;
        rst = 1;
        repeat (3) @(negedge clk);
        checks++; if (cs !== 1'b1)        begin errors++; $display("FAIL rst_cs got %b want 1", cs); end
        checks++; if (rwn !== 1'b1)       begin errors++; $display("FAIL rst_rwn got %b want 1", rwn); end
        checks++; if (rs !== 2'b00)       begin errors++; $display("FAIL rst_rs got %b want 00", rs); end
        checks++; if (wdata !== 8'h00)    begin errors++; $display("FAIL rst_wdata got %h want 00", wdata); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got %b want 0", init_done); end
        checks++; if (rx_ovr !== 1'b0)    begin errors++; $display("FAIL rst_ovr got %b want 0", rx_ovr); end
        checks++; if (txa_ready !== 1'b0) begin errors++; $display("FAIL rst_txa_ready got %b want 0", txa_ready); end
`ifdef ACIA_SEQ_RX_EN
        checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            errors++; $display("FAIL rst_rx got v=%b d=%h want v=0 d=00", rx_valid, rx_data);
        end
`endif
        rst = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            e_cs = 1'b1; e_rs = 2'b00; e_d = 8'h00;
            case (n)
                1: begin e_cs = 0; e_rs = 2'b01; e_d = 8'h00; end
                3: begin e_cs = 0; e_rs = 2'b11; e_d = 8'h1E; end
                5: begin e_cs = 0; e_rs = 2'b10; e_d = 8'h0B; end
                default: ;
            endcase
            checks++; if (cs !== e_cs) begin errors++; $display("FAIL init_cs cyc%0d got %b want %b", n, cs, e_cs); end
            if (!e_cs) begin
                checks++; if (rs !== e_rs || wdata !== e_d || rwn !== 1'b0) begin
                    errors++; $display("FAIL init_wr cyc%0d got rs=%b d=%h rwn=%b want rs=%b d=%h rwn=0", n, rs, wdata, rwn, e_rs, e_d);
                end
            end
            checks++; if (init_done !== (n == 6)) begin errors++; $display("FAIL init_done cyc%0d got %b want %b", n, init_done, n == 6); end
            checks++; if (txa_ready !== 1'b0) begin errors++; $display("FAIL init_ready cyc%0d got %b want 0", n, txa_ready); end
            if (n == 5) txa_valid = 0;
        end
    endtask

    task automatic test_tx_single();
        bit found = 0;
        int pulses = 0;
        int writes = 0;
        acia_status = 8'h10; txa_data = 8'hA5; txa_valid = 1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!cs && !rwn) begin found = 1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL tx_single_timeout got none want write"); end
        checks++; if (rs !== 2'b00 || wdata !== 8'hA5) begin errors++; $display("FAIL tx_single_wr got rs=%b d=%h want rs=00 d=a5", rs, wdata); end
        checks++; if (txa_ready !== 1'b1 || txb_ready !== 1'b0) begin
            errors++; $display("FAIL tx_single_ready got a=%b b=%b want a=1 b=0", txa_ready, txb_ready);
        end
        txa_valid = 0;
        repeat (10) begin
            @(negedge clk);
            if (txa_ready) pulses++;
            if (!cs && !rwn) writes++;
        end
        checks++; if (pulses != 0 || writes != 0) begin errors++; $display("FAIL tx_single_after got pulses=%0d writes=%0d want 0 0", pulses, writes); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_seq [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
        bit found;
        reset_init();
        acia_status = 8'h10;
        txa_data = 8'h11; txb_data = 8'h22; txa_valid = 1; txb_valid = 1;
        for (int k = 0; k < 4; k++) begin
            found = 0;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                if (!cs && !rwn) begin found = 1; break; end
            end
            checks++; if (!found || wdata !== exp_seq[k]) begin
                errors++; $display("FAIL rr_write%0d got found=%b d=%h want %h", k, found, wdata, exp_seq[k]);
            end
            checks++; if (txa_ready !== (exp_seq[k] == 8'h11) || txb_ready !== (exp_seq[k] == 8'h22)) begin
                errors++; $display("FAIL rr_ready%0d got a=%b b=%b want a=%b b=%b", k, txa_ready, txb_ready,
                                   exp_seq[k] == 8'h11, exp_seq[k] == 8'h22);
            end
        end
        txa_valid = 0; txb_valid = 0;
    endtask

    task automatic test_ovr_gap();
        bit found = 0;
        int gap = 0;
        reset_init();
        checks++; if (rx_ovr !== 1'b0) begin errors++; $display("FAIL ovr_pre got %b want 0", rx_ovr); end
        acia_status = 8'h14; txa_data = 8'h3C; txa_valid = 1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!cs && !rwn) begin found = 1; break; end
        end
        checks++; if (!found || wdata !== 8'h3C) begin errors++; $display("FAIL ovr_tx got found=%b d=%h want 3c", found, wdata); end
        checks++; if (rx_ovr !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", rx_ovr); end
        txa_valid = 0;
        acia_status = 8'h00; txa_data = 8'h77; txa_valid = 1;
        found = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!cs && rwn && rs == 2'b01) begin found = 1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL gap_poll_timeout got none want poll"); end
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (cs) gap++; else break;
        end
        // DECIDE + POLL_GAP(4) WAIT cycles + IDLE
        checks++; if (gap != 6) begin errors++; $display("FAIL gap_len got %0d want 6", gap); end
        checks++; if (cs !== 1'b0 || rwn !== 1'b1 || rs !== 2'b01) begin
            errors++; $display("FAIL gap_next got cs=%b rwn=%b rs=%b want poll 0 1 01", cs, rwn, rs);
        end
        checks++; if (rx_ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", rx_ovr); end
        txa_valid = 0;
    endtask

    task automatic test_reset_during_tx();
        bit found = 0;
        reset_init();
        acia_status = 8'h10; txa_data = 8'h5E; txa_valid = 1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!cs && rwn && rs == 2'b01) begin found = 1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL rtx_poll_timeout got none want poll"); end
        @(negedge clk);
        @(posedge clk); #1 rst = 1;
        #1;
        checks++; if (txa_ready !== 1'b0) begin errors++; $display("FAIL rtx_ready got %b want 0", txa_ready); end
        checks++; if (cs !== 1'b1) begin errors++; $display("FAIL rtx_cs_now got %b want 1", cs); end
        @(posedge clk); #2;
        checks++; if (cs !== 1'b1 || init_done !== 1'b0) begin
            errors++; $display("FAIL rtx_after got cs=%b done=%b want 1 0", cs, init_done);
        end
        txa_valid = 0;
        @(negedge clk); rst = 0;
        @(negedge clk);
        checks++; if (cs !== 1'b0 || rwn !== 1'b0 || rs !== 2'b01 || wdata !== 8'h00) begin
            errors++; $display("FAIL rtx_restart got cs=%b rwn=%b rs=%b d=%h want 0 0 01 00", cs, rwn, rs, wdata);
        end
    endtask

`ifdef ACIA_SEQ_RX_EN
    task automatic test_rx();
        bit found = 0;
        int reads = 0;
        reset_init();
        acia_rxd = 8'h5A; acia_status = 8'h08;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rx_valid) begin found = 1; break; end
        end
        checks++; if (!found || rx_data !== 8'h5A) begin errors++; $display("FAIL rx_first got v=%b d=%h want 1 5a", found, rx_data); end
        repeat (20) begin
            @(negedge clk);
            if (!cs && rwn && rs == 2'b00) reads++;
        end
        checks++; if (reads != 0 || rx_valid !== 1'b1) begin errors++; $display("FAIL rx_hold got reads=%0d v=%b want 0 1", reads, rx_valid); end
        acia_rxd = 8'hC3;
        rx_ready = 1;
        @(negedge clk);
        rx_ready = 0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_clear got %b want 0", rx_valid); end
        found = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rx_valid) begin found = 1; break; end
        end
        checks++; if (!found || rx_data !== 8'hC3) begin errors++; $display("FAIL rx_second got v=%b d=%h want 1 c3", found, rx_data); end
        acia_status = 8'h00;
    endtask
`else
    task automatic test_idle();
        bit found = 0;
        int acc = 0;
        int reads = 0;
        reset_init();
        acia_status = 8'h08;
        repeat (20) begin
            @(negedge clk);
            if (!cs) acc++;
        end
        checks++; if (acc != 0) begin errors++; $display("FAIL idle_quiet got %0d accesses want 0", acc); end
        acia_status = 8'h18; txa_data = 8'h9C; txa_valid = 1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!cs && rwn && rs == 2'b00) reads++;
            if (!cs && !rwn) begin found = 1; break; end
        end
        checks++; if (!found || wdata !== 8'h9C || reads != 0) begin
            errors++; $display("FAIL norx_tx got found=%b d=%h reads=%0d want 1 9c 0", found, wdata, reads);
        end
        txa_valid = 0;
    endtask
`endif

    initial begin
        rst = 1; txa_valid = 0; txb_valid = 0; txa_data = 0; txb_data = 0;
        acia_status = 8'h00; acia_rxd = 8'h00;
`ifdef ACIA_SEQ_RX_EN
        rx_ready = 0;
`endif
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_ovr_gap();
        test_reset_during_tx();
`ifdef ACIA_SEQ_RX_EN
        test_rx();
`else
        test_idle();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
